// File: rtl/spu_issue_scheduler.sv
`timescale 1ns/1ps
// spu_issue_scheduler: round-robin issue of two requesters' SPU operations onto one
// shared datapath, with fixed-latency result tracking and per-requester response FIFOs.
// Ports: clk/rst_n (async active-low), enable; req0/req1 valid/ready/data (16-bit op);
//   resp0/resp1 valid/ready/data (8-bit result); dp_valid/dp_ui/dp_uio issue bus,
//   dp_result return; busy; grant_cnt0/grant_cnt1 statistics.
// Optional feature: define SPU_SCHED_STATS_EN to build saturating per-requester grant counters.

// spu_resp_fifo: first-word-fall-through 8-bit response queue, DEPTH entries.
// Latency: a pushed entry appears at the head the cycle after the push.
// Backpressure: none; a push while full is dropped, so the producer must hold a free slot.
module spu_resp_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       head_valid,
    output logic [7:0] head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [2**PW];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : 8'h00;
    assign do_pop     = pop && head_valid;
    // A full FIFO may still accept a push when its head leaves in the same cycle.
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// spu_issue_scheduler: two-way round-robin arbiter feeding one SPU datapath.
// Latency: issue is combinational; a result reaches its response port DP_LATENCY+1 cycles after issue.
// Backpressure: per-requester credits stop grants once the response FIFO could overflow.
module spu_issue_scheduler #(
    parameter int DP_LATENCY = 2,
    parameter int RESP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [7:0]  resp0_data,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [7:0]  resp1_data,
    output logic        dp_valid,
    output logic [7:0]  dp_ui,
    output logic [7:0]  dp_uio,
    input  logic [7:0]  dp_result,
    output logic        busy,
    output logic [7:0]  grant_cnt0,
    output logic [7:0]  grant_cnt1
);
    localparam int             CRW         = $clog2(RESP_DEPTH + 1);
    localparam logic [CRW-1:0] CREDIT_INIT = CRW'(RESP_DEPTH);

    logic [CRW-1:0]        credit0;
    logic [CRW-1:0]        credit1;
    logic                  rr_ptr;
    logic                  elig0;
    logic                  elig1;
    logic                  grant0;
    logic                  grant1;
    logic                  pop0;
    logic                  pop1;
    logic [DP_LATENCY-1:0] trk_vld;
    logic [DP_LATENCY-1:0] trk_id;
    logic                  ret_vld;
    logic                  ret_id;

    // Gating with rst_n keeps ready and the issue bus quiet while reset is held,
    // even though the credit registers already show a full allowance.
    assign elig0 = rst_n && enable && req0_valid && (credit0 != '0);
    assign elig1 = rst_n && enable && req1_valid && (credit1 != '0);

    assign grant0 = elig0 && (!elig1 || !rr_ptr);
    assign grant1 = elig1 && (!elig0 ||  rr_ptr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign dp_valid   = grant0 || grant1;

    always_comb begin
        dp_ui  = 8'h00;
        dp_uio = 8'h00;
        if (grant0) begin
            {dp_uio, dp_ui} = req0_data;
        end else if (grant1) begin
            {dp_uio, dp_ui} = req1_data;
        end
    end

    assign pop0 = resp0_valid && resp0_ready;
    assign pop1 = resp1_valid && resp1_ready;

    function automatic logic [CRW-1:0] credit_next(input logic [CRW-1:0] cur,
                                                   input logic           grant,
                                                   input logic           pop);
        case ({grant, pop})
            2'b10:   credit_next = cur - CRW'(1);
            2'b01:   credit_next = cur + CRW'(1);
            default: credit_next = cur;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit0 <= CREDIT_INIT;
            credit1 <= CREDIT_INIT;
            rr_ptr  <= 1'b0;
        end else begin
            credit0 <= credit_next(credit0, grant0, pop0);
            credit1 <= credit_next(credit1, grant1, pop1);
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // Stage i holds the issue made i+1 cycles ago; the last stage lines up with dp_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld <= '0;
            trk_id  <= '0;
        end else begin
            trk_vld[0] <= dp_valid;
            trk_id[0]  <= grant1;
            for (int i = 1; i < DP_LATENCY; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_id[i]  <= trk_id[i-1];
            end
        end
    end

    assign ret_vld = trk_vld[DP_LATENCY-1];
    assign ret_id  = trk_id[DP_LATENCY-1];

    spu_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ret_vld && !ret_id),
        .push_data  (dp_result),
        .pop        (resp0_ready),
        .head_valid (resp0_valid),
        .head_data  (resp0_data)
    );

    spu_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ret_vld && ret_id),
        .push_data  (dp_result),
        .pop        (resp1_ready),
        .head_valid (resp1_valid),
        .head_data  (resp1_data)
    );

    assign busy = (|trk_vld) || resp0_valid || resp1_valid;

`ifdef SPU_SCHED_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else begin
            if (grant0 && (cnt0 != 8'hFF)) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (grant1 && (cnt1 != 8'hFF)) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;
`else
    assign grant_cnt0 = 8'h00;
    assign grant_cnt1 = 8'h00;
`endif
endmodule

// File: tb/tb_spu_issue_scheduler.sv
`timescale 1ns/1ps
// Bench for spu_issue_scheduler: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference model of the scheduler's behaviour.
module tb_spu_issue_scheduler;
    localparam int DPL  = 2;
    localparam int RD   = 2;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_data = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_data = '0;
    logic        resp0_valid;
    logic        resp0_ready = 1'b0;
    logic [7:0]  resp0_data;
    logic        resp1_valid;
    logic        resp1_ready = 1'b0;
    logic [7:0]  resp1_data;
    logic        dp_valid;
    logic [7:0]  dp_ui;
    logic [7:0]  dp_uio;
    logic [7:0]  dp_result = '0;
    logic        busy;
    logic [7:0]  grant_cnt0;
    logic [7:0]  grant_cnt1;

    spu_issue_scheduler #(.DP_LATENCY(DPL), .RESP_DEPTH(RD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data),
        .dp_valid    (dp_valid),
        .dp_ui       (dp_ui),
        .dp_uio      (dp_uio),
        .dp_result   (dp_result),
        .busy        (busy),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Stimulus for the next cycle, applied 1ns after the rising edge.
    logic        nx_rst_n;
    logic        nx_en;
    logic        nx_v0;
    logic        nx_v1;
    logic        nx_r0;
    logic        nx_r1;
    logic [15:0] nx_d0;
    logic [15:0] nx_d1;

    // Reference model state.
    typedef struct {
        int         due;
        bit         id;
        logic [7:0] res;
    } inf_t;
    inf_t       infl[$];
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    int         credit[2];
    int         rr;
    int         gc[2];

    // Datapath emulation history.
    logic        hv [MAXC];
    logic [15:0] hd [MAXC];

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stand-in datapath: Manhattan pair, box area, or 0 for the reserved selectors.
    function automatic logic [7:0] dpfun(input logic [15:0] d);
        logic [3:0] a, b, h, l;
        logic [2:0] c, e;
        logic [7:0] p;
        a = d[3:0];
        b = d[7:4];
        c = d[10:8];
        e = d[13:11];
        h = (a > b) ? a - b : b - a;
        l = (c > e) ? {1'b0, c - e} : {1'b0, e - c};
        p = {4'b0, a} * {4'b0, b};
        case (d[15:14])
            2'b00:   return {h, l};
            2'b01:   return p;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        infl.delete();
        fq0.delete();
        fq1.delete();
        credit[0] = RD;
        credit[1] = RD;
        rr        = 0;
        gc[0]     = 0;
        gc[1]     = 0;
    endtask

    task automatic cycle();
        logic e0, e1, g0, g1;
        logic [7:0] x_ui, x_uio, x_c0, x_c1;
        inf_t t;
        @(posedge clk);
        #1;
        rst_n       = nx_rst_n;
        enable      = nx_en;
        req0_valid  = nx_v0;
        req1_valid  = nx_v1;
        req0_data   = nx_d0;
        req1_data   = nx_d1;
        resp0_ready = nx_r0;
        resp1_ready = nx_r1;
        if (cyc >= DPL && (cyc - DPL) < MAXC && hv[cyc - DPL]) begin
            dp_result = dpfun(hd[cyc - DPL]);
        end else begin
            dp_result = 8'($urandom);
        end
        if (!rst_n) begin
            model_reset();
        end
        #4;
        e0 = rst_n && enable && req0_valid && (credit[0] > 0);
        e1 = rst_n && enable && req1_valid && (credit[1] > 0);
        g0 = e0 && (!e1 || rr == 0);
        g1 = e1 && (!e0 || rr == 1);
        x_ui  = g0 ? req0_data[7:0]  : (g1 ? req1_data[7:0]  : 8'h00);
        x_uio = g0 ? req0_data[15:8] : (g1 ? req1_data[15:8] : 8'h00);
`ifdef SPU_SCHED_STATS_EN
        x_c0 = 8'(gc[0]);
        x_c1 = 8'(gc[1]);
`else
        x_c0 = 8'h00;
        x_c1 = 8'h00;
`endif
        chk("req0_ready",  32'(req0_ready),  32'(g0));
        chk("req1_ready",  32'(req1_ready),  32'(g1));
        chk("dp_valid",    32'(dp_valid),    32'(g0 || g1));
        chk("dp_ui",       32'(dp_ui),       32'(x_ui));
        chk("dp_uio",      32'(dp_uio),      32'(x_uio));
        chk("resp0_valid", 32'(resp0_valid), 32'(fq0.size() > 0));
        chk("resp0_data",  32'(resp0_data),  32'((fq0.size() > 0) ? fq0[0] : 8'h00));
        chk("resp1_valid", 32'(resp1_valid), 32'(fq1.size() > 0));
        chk("resp1_data",  32'(resp1_data),  32'((fq1.size() > 0) ? fq1[0] : 8'h00));
        chk("busy",        32'(busy),        32'(infl.size() > 0 || fq0.size() > 0 || fq1.size() > 0));
        chk("grant_cnt0",  32'(grant_cnt0),  32'(x_c0));
        chk("grant_cnt1",  32'(grant_cnt1),  32'(x_c1));
        if (cyc < MAXC) begin
            hv[cyc] = dp_valid;
            hd[cyc] = {dp_uio, dp_ui};
        end
        if (rst_n) begin
            if (fq0.size() > 0 && resp0_ready) begin
                fq0.delete(0);
                credit[0]++;
            end
            if (fq1.size() > 0 && resp1_ready) begin
                fq1.delete(0);
                credit[1]++;
            end
            while (infl.size() > 0 && infl[0].due == cyc) begin
                t = infl.pop_front();
                if (t.id) fq1.push_back(t.res);
                else      fq0.push_back(t.res);
            end
            if (g0) begin
                t.due = cyc + DPL; t.id = 1'b0; t.res = dpfun(req0_data);
                infl.push_back(t);
                credit[0]--;
                rr = 1;
                if (gc[0] < 255) gc[0]++;
            end else if (g1) begin
                t.due = cyc + DPL; t.id = 1'b1; t.res = dpfun(req1_data);
                infl.push_back(t);
                credit[1]--;
                rr = 0;
                if (gc[1] < 255) gc[1]++;
            end
        end
        cyc++;
    endtask

    task automatic set_idle();
        nx_en = 1'b1;
        nx_v0 = 1'b0;
        nx_v1 = 1'b0;
        nx_r0 = 1'b1;
        nx_r1 = 1'b1;
        nx_d0 = '0;
        nx_d1 = '0;
    endtask

    task automatic do_reset();
        set_idle();
        nx_rst_n = 1'b0;
        cycle();
        nx_rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        model_reset();
        set_idle();
        nx_rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_dp_valid",  32'(dp_valid),    32'd0);
        chk("rst_resp0_vld", 32'(resp0_valid), 32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        nx_rst_n = 1'b1;
        cycle();

        // Single request: A=3 B=1 C=5 D=2 OpSel=0.
        nx_v0 = 1'b1;
        nx_d0 = 16'h1513;
        cycle();
        chk("single_issue", 32'(dp_valid), 32'd1);
        chk("single_ui",    32'(dp_ui),    32'h13);
        chk("single_uio",   32'(dp_uio),   32'h15);
        nx_v0 = 1'b0;
        cycle();
        chk("single_t1_resp", 32'(resp0_valid), 32'd0);
        chk("single_t1_busy", 32'(busy),        32'd1);
        cycle();
        chk("single_t2_resp", 32'(resp0_valid), 32'd0);
        cycle();
        chk("single_t3_resp", 32'(resp0_valid), 32'd1);
        chk("single_t3_data", 32'(resp0_data),  32'h23);
        cycle();
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Contention: alternate grants starting with requester 0, one issue per cycle.
        do_reset();
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            nx_d0 = 16'($urandom);
            nx_d1 = 16'($urandom);
            cycle();
            if (i == 0) chk("cont_first_g0",  32'({req0_ready, req1_ready}), 32'b10);
            if (i == 1) chk("cont_second_g1", 32'({req0_ready, req1_ready}), 32'b01);
            n += int'(dp_valid);
        end
        chk("cont_issues", 32'(n), 32'd20);

        // Credit stall.
        set_idle();
        repeat (8) cycle();
        nx_v0 = 1'b1;
        nx_r0 = 1'b0;
        n = 0;
        repeat (10) begin
            cycle();
            n += int'(req0_ready);
        end
        chk("stall_grants", 32'(n), 32'd2);
        nx_r0 = 1'b1;
        cycle();
        chk("stall_pop_cycle", 32'(req0_ready), 32'd0);
        nx_r0 = 1'b0;
        cycle();
        chk("stall_after_pop", 32'(req0_ready), 32'd1);
        n = 0;
        repeat (5) begin
            cycle();
            n += int'(req0_ready);
        end
        chk("stall_hold", 32'(n), 32'd0);

        // Enable drop with two operations in flight.
        set_idle();
        repeat (8) cycle();
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        nx_r0 = 1'b0;
        nx_r1 = 1'b0;
        nx_d0 = 16'h2A74;
        nx_d1 = 16'h4C39;
        repeat (2) cycle();
        nx_en = 1'b0;
        n = 0;
        repeat (6) begin
            cycle();
            n += int'(dp_valid);
        end
        chk("endrop_issues", 32'(n),           32'd0);
        chk("endrop_resp0",  32'(resp0_valid), 32'd1);
        chk("endrop_resp1",  32'(resp1_valid), 32'd1);
        chk("endrop_busy",   32'(busy),        32'd1);
        nx_r0 = 1'b1;
        nx_r1 = 1'b1;
        cycle();
        chk("endrop_drain_busy", 32'(busy), 32'd1);
        cycle();
        chk("endrop_idle_busy",  32'(busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            nx_en = ($urandom_range(0, 7) != 0);
            nx_v0 = ($urandom_range(0, 3) != 0);
            nx_v1 = ($urandom_range(0, 3) != 0);
            nx_r0 = ($urandom_range(0, 2) != 0);
            nx_r1 = ($urandom_range(0, 2) != 0);
            nx_d0 = 16'($urandom);
            nx_d1 = 16'($urandom);
            cycle();
        end

        // Reset with operations in flight.
        set_idle();
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        nx_d0 = 16'h0F21;
        nx_d1 = 16'h1387;
        repeat (2) cycle();
        nx_rst_n = 1'b0;
        cycle();
        chk("midrst_dp_valid", 32'(dp_valid),                   32'd0);
        chk("midrst_ready",    32'({req0_ready, req1_ready}),   32'd0);
        chk("midrst_resp",     32'({resp0_valid, resp1_valid}), 32'd0);
        chk("midrst_busy",     32'(busy),                       32'd0);
        nx_rst_n = 1'b1;
        set_idle();
        n = 0;
        repeat (8) begin
            cycle();
            n += int'(resp0_valid) + int'(resp1_valid);
        end
        chk("midrst_no_resp", 32'(n), 32'd0);

        // Grant-counter saturation.
        do_reset();
        nx_v0 = 1'b1;
        n = 0;
        k = 0;
        while (n < 300 && k < 3000) begin
            nx_d0 = 16'($urandom);
            cycle();
            n += int'(req0_ready);
            k++;
        end
        chk("stats_grants", 32'(n), 32'd300);
        set_idle();
        cycle();
`ifdef SPU_SCHED_STATS_EN
        chk("stats_cnt0", 32'(grant_cnt0), 32'd255);
`else
        chk("stats_cnt0", 32'(grant_cnt0), 32'd0);
`endif
        chk("stats_cnt1", 32'(grant_cnt1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spu_issue_scheduler.md
# spu_issue_scheduler

Round-robin scheduler that shares one Spatial Processing Unit (SPU) datapath between two requesters. Each requester submits operations over a valid/ready port. The scheduler issues at most one operation per cycle to the datapath. It tracks each in-flight operation through the datapath's fixed latency and returns the 8-bit result to the originating requester through a per-requester response FIFO. It sits between host-side command sources and the registered Manhattan-distance / box-area datapath.

## Interface
- `DP_LATENCY`, default 2: cycles from issue until `dp_result` is valid. Legal range 1–8.
- `RESP_DEPTH`, default 2: response FIFO depth per requester. Legal range 1–4.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  grants are allowed only while this is high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0's operation is accepted this cycle.
- `req0_data`  in  16  packed operation. `[3:0]`=A, `[7:4]`=B, `[10:8]`=C, `[13:11]`=D, `[15:14]`=OpSel.
- `req1_valid`, `req1_ready`, `req1_data`: same as requester 0, for requester 1.
- `resp0_valid`  out  1  requester 0 FIFO head is valid.
- `resp0_ready`  in  1  requester 0 pops its FIFO head.
- `resp0_data`  out  8  requester 0 result, `{high, low}` nibbles.
- `resp1_valid`, `resp1_ready`, `resp1_data`: same as requester 0, for requester 1.
- `dp_valid`  out  1  an issue happens this cycle.
- `dp_ui`  out  8  datapath `ui_in`, equal to `req_data[7:0]` of the granted requester; 0 when idle.
- `dp_uio`  out  8  datapath `uio_in`, equal to `req_data[15:8]` of the granted requester; 0 when idle.
- `dp_result`  in  8  datapath result.
- `busy`  out  1  an operation is in flight or either response FIFO is non-empty.
- `grant_cnt0`, `grant_cnt1`  out  8  per-requester grant counters (see Configuration).

## Operation
- **Eligibility:** requester N is eligible when `reqN_valid`, `enable`, and `credit[N]>0` are all true.
- **Credits:** `credit[N]` resets to `RESP_DEPTH`.
  - Decrements on a grant to N.
  - Increments on a pop (`respN_valid && respN_ready`).
  - Holds when a grant and a pop happen in the same cycle.
  - Credits guarantee a FIFO slot for every in-flight result, so the FIFOs can never overflow.
- **Arbitration:**
  - Only one requester eligible: it is granted.
  - Both eligible: `rr_ptr` wins.
  - After any grant, `rr_ptr` becomes the other requester.
  - `rr_ptr` resets to 0.
  - With no grant, `rr_ptr` holds.
- **Ready is combinational:** `reqN_ready` equals grant N and depends on `reqN_valid`. Requesters must not make `valid` depend on `ready`.
- **Issue:** on a grant, `dp_valid=1` and `dp_ui`/`dp_uio` take the granted requester's data.
- **Tracking:** a `DP_LATENCY`-stage shift register carries `{valid, id}` for each issue. At the stage-`DP_LATENCY` output, `dp_result` is pushed into FIFO[id].
- **OpSel:** passed through unchanged. OpSel 2'b10 and 2'b11 still issue and return the datapath's 0.
- **FIFOs:**
  - Each FIFO is `RESP_DEPTH` deep, first-word-fall-through, and holds 8 bits per entry.
  - A push and a pop in the same cycle are both honoured.
  - `respN_data` is 0 when the FIFO is empty.
- **Enable low:** no new grants; in-flight operations complete; FIFOs continue to drain.
- **Reset values:**
  - FIFOs and tracking register empty; all credits = `RESP_DEPTH`.
  - `req*_ready` and `resp*_valid` = 0; `dp_valid`, `dp_ui`, `dp_uio` = 0; `resp*_data` = 0.
  - `busy` = 0; grant counters = 0.
- **Reset mid-operation:** all in-flight results are discarded. Any datapath output after reset is ignored because the tracking register is empty.

## Timing
- An issue in cycle T means the datapath samples `dp_ui`/`dp_uio` at the end of cycle T.
- `dp_result` is captured at the end of cycle T+`DP_LATENCY`.
- `respN_valid` is high from cycle T+`DP_LATENCY`+1. With the default parameters, issue-to-response latency is 3 cycles.
- Throughput is one issue per cycle, sustained when both requesters hold credits and pop promptly.
- A pop frees its credit in the following cycle: the credit register updates at the clock edge.
- `busy` is registered-state-derived. It rises in cycle T+1 after an issue in cycle T.
- `busy` falls the cycle after the last FIFO entry is popped with nothing in flight.

## Configuration
- `SPU_SCHED_STATS_EN` defined:
  - `grant_cnt0` and `grant_cnt1` count grants per requester.
  - They saturate at 255 and clear only on reset.
- `SPU_SCHED_STATS_EN` undefined: the counters are not built, and `grant_cnt0`/`grant_cnt1` are constant 0.

## Test plan
- **Single request:** reset; `enable=1`; `req0` with A=3, B=1, C=5, D=2, OpSel=0, datapath model computing |A−B|,|C−D| → `dp_valid` in cycle T; `resp0_valid` in T+3 with `resp0_data`=8'h23; `busy` low after the pop.
- **Contention:** both requesters valid continuously with `resp*_ready=1` → grants alternate 0,1,0,1 starting with 0; each response is routed to its own port in order; one issue per cycle.
- **Credit stall:** `resp0_ready=0`, `req0` valid continuously → exactly 2 grants, then `req0_ready` stays 0; one pop → exactly one further grant, one cycle after the pop.
- **Enable drop:** `enable` deasserted with 2 operations in flight → no new `dp_valid`; both results still arrive; `busy` holds until the FIFOs drain.
- **Reset mid-flight:** `rst_n` pulsed low with operations in flight → all outputs 0 immediately; no responses appear afterwards.
- **Stats (macro defined):** 300 grants to requester 0 → `grant_cnt0`=255; `grant_cnt1` unchanged.
